// File: rtl/clamp_if.sv
// Bias-vector and clamp-control bundle between the bias/weight stage and the
// clamp ramp sequencer.
interface clamp_if #(
  parameter int NUM_PBITS = 91,
  parameter int H_W       = 8,
  parameter int NUM_CLAMP = 8,
  parameter int RATE_W    = 16
);
  logic [NUM_PBITS*H_W-1:0] h_in;
  logic [NUM_CLAMP-1:0]     clamp_val;
  logic                     clamp_valid;
  logic                     clamp_ready;
  logic                     release_req;
  logic                     mode;
  logic [RATE_W-1:0]        rate;
  logic [NUM_PBITS*H_W-1:0] h_out;
  logic [H_W-2:0]           strength;
  logic                     busy;

  modport master (
    output h_in, clamp_val, clamp_valid, release_req, mode, rate,
    input  clamp_ready, h_out, strength, busy
  );

  modport slave (
    input  h_in, clamp_val, clamp_valid, release_req, mode, rate,
    output clamp_ready, h_out, strength, busy
  );
endinterface

// File: rtl/clamp_ramp_sequencer.sv
// Annealed clamp: ramps a window of p-bit biases toward a latched pattern in
// RAMP_STEP increments, holds at full strength, then ramps back down on release.
module clamp_ramp_sequencer #(
  parameter int NUM_PBITS = 91,
  parameter int H_W       = 8,
  parameter int CLAMP_LO  = 45,
  parameter int NUM_CLAMP = 8,
  parameter int RAMP_STEP = 16,
  parameter int RATE_W    = 16
) (
  input  logic   clk,
  input  logic   rst,
  clamp_if.slave bus
);

  localparam int S_W  = H_W - 1;
  localparam int SMAX = 2**(H_W-1) - 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RAMP    = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Saturation bounds at H_W+1 bits.
  localparam logic signed [H_W:0] B_MAX = {2'b00, {(H_W-1){1'b1}}};
  localparam logic signed [H_W:0] B_MIN = {2'b11, {(H_W-1){1'b0}}};

  if (CLAMP_LO + NUM_CLAMP > NUM_PBITS) begin : g_bad_window
    $error("clamp window [%0d +: %0d] exceeds NUM_PBITS=%0d", CLAMP_LO, NUM_CLAMP, NUM_PBITS);
  end
  if (RAMP_STEP < 1) begin : g_bad_step
    $error("RAMP_STEP must be >= 1, got %0d", RAMP_STEP);
  end

  logic [1:0]               state_q, state_d;
  logic [S_W-1:0]           s_q, s_d;
  logic [NUM_CLAMP-1:0]     pattern_q, pattern_d;
  logic [RATE_W-1:0]        timer_q, timer_d;
  logic [NUM_PBITS*H_W-1:0] h_q, h_d;
  logic                     step;

  // A lowered rate that is already below the running timer still fires at the
  // next compare instead of waiting for the timer to wrap.
  assign step = (timer_q >= bus.rate);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    pattern_d = pattern_q;
    timer_d   = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clamp_valid) begin
          pattern_d = bus.clamp_val;
          s_d       = '0;
          timer_d   = '0;
          state_d   = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (bus.release_req) begin
          timer_d = '0;
          state_d = ST_RELEASE;
        end else if (step) begin
          timer_d = '0;
          if (int'(s_q) + RAMP_STEP >= SMAX) begin
            s_d     = S_W'(SMAX);
            state_d = ST_HOLD;
          end else begin
            s_d = S_W'(int'(s_q) + RAMP_STEP);
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.release_req) begin
          timer_d = '0;
          state_d = ST_RELEASE;
        end
      end
      default: begin
        if (step) begin
          timer_d = '0;
          if (int'(s_q) <= RAMP_STEP) begin
            s_d     = '0;
            state_d = ST_IDLE;
          end else begin
            s_d = S_W'(int'(s_q) - RAMP_STEP);
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    endcase
  end

  // Bias datapath: a set pattern bit drives a negative bias, matching the
  // legacy clamp; full strength on a set bit maps to the most negative code.
  logic signed [H_W-1:0] elem;
  logic signed [H_W:0]   s_pos, bias, sum;

  assign s_pos = $signed({2'b00, s_q});

  always_comb begin
    h_d  = bus.h_in;
    elem = '0;
    bias = '0;
    sum  = '0;
    if (state_q != ST_IDLE) begin
      for (int j = 0; j < NUM_CLAMP; j++) begin
        elem = bus.h_in[(CLAMP_LO+j)*H_W +: H_W];
        if (!pattern_q[j])               bias = s_pos;
        else if (s_q == {S_W{1'b1}})     bias = B_MIN;
        else                             bias = -s_pos;
        sum = $signed({elem[H_W-1], elem}) + bias;
        if (!bus.mode)         h_d[(CLAMP_LO+j)*H_W +: H_W] = bias[H_W-1:0];
        else if (sum > B_MAX)  h_d[(CLAMP_LO+j)*H_W +: H_W] = B_MAX[H_W-1:0];
        else if (sum < B_MIN)  h_d[(CLAMP_LO+j)*H_W +: H_W] = B_MIN[H_W-1:0];
        else                   h_d[(CLAMP_LO+j)*H_W +: H_W] = sum[H_W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      pattern_q <= '0;
      timer_q   <= '0;
      h_q       <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      pattern_q <= pattern_d;
      timer_q   <= timer_d;
      h_q       <= h_d;
    end
  end

  assign bus.h_out       = h_q;
  assign bus.strength    = s_q;
  assign bus.clamp_ready = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clamp_ramp_sequencer.sv
// Directed bench for clamp_ramp_sequencer: reset, ramp, hold, release,
// saturating mode, ignored requests and release during ramp.
module tb_clamp_ramp_sequencer;

  logic clk;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  clamp_if #(.NUM_PBITS(91), .H_W(8), .NUM_CLAMP(8), .RATE_W(16)) bus ();

  clamp_ramp_sequencer #(
    .NUM_PBITS(91), .H_W(8), .CLAMP_LO(45), .NUM_CLAMP(8), .RAMP_STEP(16), .RATE_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int i = 0; i < 91; i++) bus.h_in[i*8 +: 8] = v;
  endtask

  function automatic logic [7:0] hout(input int i);
    return bus.h_out[i*8 +: 8];
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!bus.clamp_ready && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (bus.clamp_ready !== 1'b1) $display("FAIL wait_idle: clamp_ready=%b want 1 within %0d cycles", bus.clamp_ready, budget);
    else passed++;
  endtask

  task automatic start_clamp(input logic [7:0] pat);
    bus.clamp_val   = pat;
    bus.clamp_valid = 1'b1;
    tick();
    bus.clamp_valid = 1'b0;
  endtask

  task automatic pulse_release();
    bus.release_req = 1'b1;
    tick();
    bus.release_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++; if (bus.h_out !== '0)       $display("FAIL reset_h_out: got nonzero want 0"); else passed++;
    total++; if (bus.strength !== 7'd0)  $display("FAIL reset_strength: got %0d want 0", bus.strength); else passed++;
    total++; if (bus.clamp_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.clamp_ready); else passed++;
    total++; if (bus.busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_ramp();
    bus.mode = 1'b0; bus.rate = '0; set_all(8'd3);
    start_clamp(8'hA5);
    repeat (3) tick();
    total++; if (bus.strength !== 7'd48) $display("FAIL midramp_pre_s: got %0d want 48", bus.strength); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (bus.h_out !== '0)       $display("FAIL midramp_h_out: got nonzero want 0"); else passed++;
    total++; if (bus.strength !== 7'd0)  $display("FAIL midramp_s: got %0d want 0", bus.strength); else passed++;
    total++; if (bus.clamp_ready !== 1'b1) $display("FAIL midramp_ready: got %b want 1", bus.clamp_ready); else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp_up();
    int exp_s;
    bus.mode = 1'b0; bus.rate = '0; set_all(8'd3);
    start_clamp(8'hA5);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_s = (16*k > 127) ? 127 : 16*k;
      total++; if (bus.strength !== 7'(exp_s)) $display("FAIL ramp_s%0d: got %0d want %0d", k, bus.strength, exp_s); else passed++;
    end
    total++; if (bus.busy !== 1'b1 || bus.clamp_ready !== 1'b0) $display("FAIL ramp_busy: busy=%b ready=%b want 1/0", bus.busy, bus.clamp_ready); else passed++;
    tick();
    total++; if (hout(45) !== 8'h80) $display("FAIL hold_idx45: got %h want 80", hout(45)); else passed++;
    total++; if (hout(46) !== 8'h7F) $display("FAIL hold_idx46: got %h want 7f", hout(46)); else passed++;
    total++; if (hout(52) !== 8'h80) $display("FAIL hold_idx52: got %h want 80", hout(52)); else passed++;
    total++; if (hout(0) !== 8'h03)  $display("FAIL hold_idx0: got %h want 03", hout(0)); else passed++;
    total++; if (hout(44) !== 8'h03 || hout(53) !== 8'h03) $display("FAIL hold_edges: got %h/%h want 03/03", hout(44), hout(53)); else passed++;
    total++; if (bus.strength !== 7'd127) $display("FAIL hold_s: got %0d want 127", bus.strength); else passed++;
  endtask

  task automatic test_release_rate();
    int prev_s;
    int exp_s;
    bus.rate = 16'd3;
    pulse_release();
    total++; if (bus.strength !== 7'd127 || bus.busy !== 1'b1) $display("FAIL rel_entry: s=%0d busy=%b want 127/1", bus.strength, bus.busy); else passed++;
    prev_s = 127;
    for (int k = 1; k <= 8; k++) begin
      repeat (3) tick();
      total++; if (bus.strength !== 7'(prev_s)) $display("FAIL rel_wait%0d: got %0d want %0d", k, bus.strength, prev_s); else passed++;
      tick();
      exp_s = (127 - 16*k < 0) ? 0 : 127 - 16*k;
      total++; if (bus.strength !== 7'(exp_s)) $display("FAIL rel_step%0d: got %0d want %0d", k, bus.strength, exp_s); else passed++;
      prev_s = exp_s;
    end
    total++; if (bus.clamp_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL rel_idle: ready=%b busy=%b want 1/0", bus.clamp_ready, bus.busy); else passed++;
    tick();
    total++; if (hout(45) !== 8'h03) $display("FAIL idle_pass0: got %h want 03", hout(45)); else passed++;
  endtask

  task automatic test_saturate();
    bus.mode = 1'b1; bus.rate = '0; set_all(8'd3);
    bus.h_in[45*8 +: 8] = 8'h9C;
    bus.h_in[46*8 +: 8] = 8'h64;
    tick();
    total++; if (hout(45) !== 8'h9C || hout(46) !== 8'h64) $display("FAIL idle_pass1: got %h/%h want 9c/64", hout(45), hout(46)); else passed++;
    start_clamp(8'hA5);
    repeat (8) tick();
    total++; if (bus.strength !== 7'd127) $display("FAIL sat_s: got %0d want 127", bus.strength); else passed++;
    tick();
    total++; if (hout(45) !== 8'h80) $display("FAIL sat_idx45: got %h want 80", hout(45)); else passed++;
    total++; if (hout(46) !== 8'h7F) $display("FAIL sat_idx46: got %h want 7f", hout(46)); else passed++;
    total++; if (hout(47) !== 8'h83) $display("FAIL add_idx47: got %h want 83", hout(47)); else passed++;
    total++; if (hout(48) !== 8'h7F) $display("FAIL sat_idx48: got %h want 7f", hout(48)); else passed++;
    total++; if (hout(0) !== 8'h03)  $display("FAIL sat_idx0: got %h want 03", hout(0)); else passed++;
    pulse_release();
    wait_idle(20);
  endtask

  task automatic test_valid_ignored();
    bus.mode = 1'b0; bus.rate = '0; set_all(8'd0);
    start_clamp(8'h0F);
    tick();
    bus.clamp_val   = 8'hF0;
    bus.clamp_valid = 1'b1;
    tick();
    bus.clamp_valid = 1'b0;
    total++; if (bus.strength !== 7'd32 || bus.clamp_ready !== 1'b0) $display("FAIL ign_ramp: s=%0d ready=%b want 32/0", bus.strength, bus.clamp_ready); else passed++;
    repeat (6) tick();
    total++; if (bus.strength !== 7'd127) $display("FAIL ign_hold_s: got %0d want 127", bus.strength); else passed++;
    tick();
    total++; if (hout(45) !== 8'h80 || hout(52) !== 8'h7F) $display("FAIL ign_hold_pat: got %h/%h want 80/7f", hout(45), hout(52)); else passed++;
    pulse_release();
    tick();
    tick();
    total++; if (bus.strength !== 7'd95) $display("FAIL ign_rel_s: got %0d want 95", bus.strength); else passed++;
    total++; if (hout(45) !== 8'h91 || hout(52) !== 8'h6F) $display("FAIL ign_rel_pat: got %h/%h want 91/6f", hout(45), hout(52)); else passed++;
    wait_idle(20);
  endtask

  task automatic test_release_in_ramp();
    int exp_s;
    bus.mode = 1'b0; bus.rate = '0; set_all(8'd3);
    start_clamp(8'hA5);
    repeat (4) tick();
    total++; if (bus.strength !== 7'd64) $display("FAIL rr_pre: got %0d want 64", bus.strength); else passed++;
    pulse_release();
    total++; if (bus.strength !== 7'd64 || bus.busy !== 1'b1) $display("FAIL rr_entry: s=%0d busy=%b want 64/1", bus.strength, bus.busy); else passed++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_s = 64 - 16*k;
      total++; if (bus.strength !== 7'(exp_s)) $display("FAIL rr_step%0d: got %0d want %0d", k, bus.strength, exp_s); else passed++;
    end
    total++; if (bus.clamp_ready !== 1'b1) $display("FAIL rr_idle: ready=%b want 1", bus.clamp_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    bus.mode = 1'b0; bus.rate = '0;
    start_clamp(8'h00);
    total++; if (bus.busy !== 1'b1 || bus.strength !== 7'd0) $display("FAIL b2b_accept: busy=%b s=%0d want 1/0", bus.busy, bus.strength); else passed++;
    tick();
    total++; if (bus.strength !== 7'd16) $display("FAIL b2b_step: got %0d want 16", bus.strength); else passed++;
    pulse_release();
    wait_idle(10);
  endtask

  initial begin
    bus.h_in        = '0;
    bus.clamp_val   = '0;
    bus.clamp_valid = 1'b0;
    bus.release_req = 1'b0;
    bus.mode        = 1'b0;
    bus.rate        = '0;
    test_reset();
    test_reset_mid_ramp();
    test_ramp_up();
    test_release_rate();
    test_saturate();
    test_valid_ignored();
    test_release_in_ramp();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
